// File: rtl/branch_predictor_if.sv
// Bus bundle between the fetch/execute pipeline and the branch predictor.
interface branch_predictor_if;
    logic [31:0] pc_f_i;
    logic        pred_taken_f_o;
    logic [31:0] pred_target_f_o;
    logic        instr_valid_e_i;
    logic        update_en_e_i;
    logic [31:0] pc_e_i;
    logic        pc_src_res_e_i;
    logic [31:0] target_e_i;
    logic        pred_taken_e_i;
    logic [31:0] pred_target_e_i;
    logic        mispredict_e_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    // Pipeline side: drives fetch PC and resolved E-stage outcomes.
    modport master (
        output pc_f_i, instr_valid_e_i, update_en_e_i, pc_e_i, pc_src_res_e_i,
               target_e_i, pred_taken_e_i, pred_target_e_i,
        input  pred_taken_f_o, pred_target_f_o, mispredict_e_o, branch_cnt_o,
               mispred_cnt_o
    );

    // Predictor side.
    modport slave (
        input  pc_f_i, instr_valid_e_i, update_en_e_i, pc_e_i, pc_src_res_e_i,
               target_e_i, pred_taken_e_i, pred_target_e_i,
        output pred_taken_f_o, pred_target_f_o, mispredict_e_o, branch_cnt_o,
               mispred_cnt_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-stage BTB with 2-bit saturating direction counters, E-stage update,
// mispredict detection and saturating performance counters.
module branch_predictor #(
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned TAG_W   = 8
) (
    input logic                clk_i,
    input logic                rst_n_i,
    branch_predictor_if.slave  bp
);
    localparam int unsigned INDEX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_LO  = INDEX_W + 2;
    localparam int unsigned TAG_HI  = INDEX_W + TAG_W + 1;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];

    logic [31:0]       branch_cnt_q;
    logic [31:0]       mispred_cnt_q;

    logic [INDEX_W-1:0] idx_f;
    logic [INDEX_W-1:0] idx_e;
    logic [TAG_W-1:0]   tag_f;
    logic [TAG_W-1:0]   tag_e;
    logic               hit_f;
    logic               hit_e;
    logic               mispredict_c;

    logic               set_valid;
    logic               clr_valid;
    logic               wr_tag;
    logic               wr_target;
    logic               wr_ctr;
    logic [1:0]         ctr_nxt;

    logic               unused_pc_bits;

    assign idx_f = bp.pc_f_i[INDEX_W+1:2];
    assign tag_f = bp.pc_f_i[TAG_HI:TAG_LO];
    assign idx_e = bp.pc_e_i[INDEX_W+1:2];
    assign tag_e = bp.pc_e_i[TAG_HI:TAG_LO];

    assign unused_pc_bits = ^{bp.pc_f_i[31:TAG_HI+1], bp.pc_f_i[1:0],
                              bp.pc_e_i[31:TAG_HI+1], bp.pc_e_i[1:0]};

    // Fetch lookup: combinational, sees pre-update contents.
    assign hit_f              = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_e              = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign bp.pred_taken_f_o  = hit_f && ctr_q[idx_f][1];
    assign bp.pred_target_f_o = hit_f ? target_q[idx_f] : 32'd0;

    // Mispredict: direction error, taken-target error, or alias hit on a non-branch.
    always_comb begin
        mispredict_c = 1'b0;
        if (bp.instr_valid_e_i) begin
            if (bp.update_en_e_i) begin
                mispredict_c = (bp.pred_taken_e_i != bp.pc_src_res_e_i) ||
                               (bp.pred_taken_e_i && bp.pc_src_res_e_i &&
                                (bp.pred_target_e_i != bp.target_e_i));
            end else begin
                mispredict_c = bp.pred_taken_e_i;
            end
        end
    end
    assign bp.mispredict_e_o = mispredict_c;

    // Table update decode for the E-stage instruction.
    always_comb begin
        set_valid = 1'b0;
        clr_valid = 1'b0;
        wr_tag    = 1'b0;
        wr_target = 1'b0;
        wr_ctr    = 1'b0;
        ctr_nxt   = ctr_q[idx_e];
        if (bp.instr_valid_e_i) begin
            if (bp.update_en_e_i) begin
                if (hit_e) begin
                    wr_ctr    = 1'b1;
                    wr_target = bp.pc_src_res_e_i;
                    if (bp.pc_src_res_e_i) begin
                        ctr_nxt = (ctr_q[idx_e] == 2'b11) ? 2'b11 : ctr_q[idx_e] + 2'd1;
                    end else begin
                        ctr_nxt = (ctr_q[idx_e] == 2'b00) ? 2'b00 : ctr_q[idx_e] - 2'd1;
                    end
                end else if (bp.pc_src_res_e_i) begin
                    set_valid = 1'b1;
                    wr_tag    = 1'b1;
                    wr_target = 1'b1;
                    wr_ctr    = 1'b1;
                    ctr_nxt   = 2'b10;
                end
            end else if (bp.pred_taken_e_i) begin
                clr_valid = 1'b1;
            end
        end
    end

    // Valid bits and direction counters: cleared to weakly-not-taken on reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else begin
            if (set_valid) begin
                valid_q[idx_e] <= 1'b1;
            end else if (clr_valid) begin
                valid_q[idx_e] <= 1'b0;
            end
            if (wr_ctr) begin
                ctr_q[idx_e] <= ctr_nxt;
            end
        end
    end

    // Tags and targets: no reset value, but writes are blocked during reset.
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            if (wr_tag) begin
                tag_q[idx_e] <= tag_e;
            end
            if (wr_target) begin
                target_q[idx_e] <= bp.target_e_i;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            branch_cnt_q  <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            if (bp.instr_valid_e_i && bp.update_en_e_i && (branch_cnt_q != 32'hFFFF_FFFF)) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispredict_c && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign bp.branch_cnt_o  = branch_cnt_q;
    assign bp.mispred_cnt_o = mispred_cnt_q;
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage branch target buffer with 2-bit saturating direction counters.
- Fetch side: gives a taken prediction and predicted target for the current fetch PC.
- Execute side: consumes the resolved outcome from the branch resolution logic (pc_src_res), updates the table, and flags mispredictions so the hazard unit flushes F/D and redirects the PC.
- Also keeps saturating branch and mispredict performance counters.

Parameters:
- ENTRIES, 32, number of table entries (power of two, >=2).
- INDEX_W, $clog2(ENTRIES), index width, derived.
- TAG_W, 8, partial tag width.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  synchronous active-low reset.
- pc_f_i  in  32  fetch PC.
- pred_taken_f_o  out  1  predict taken for pc_f_i.
- pred_target_f_o  out  32  predicted target for pc_f_i.
- instr_valid_e_i  in  1  E-stage slot holds a real, unflushed instruction.
- update_en_e_i  in  1  E instruction is a branch or jump (branch_op != NON_BRANCH).
- pc_e_i  in  32  PC of E instruction.
- pc_src_res_e_i  in  1  resolved taken, from resolution unit.
- target_e_i  in  32  computed target of E instruction.
- pred_taken_e_i  in  1  prediction carried down the pipe with the instruction.
- pred_target_e_i  in  32  predicted target carried down the pipe.
- mispredict_e_o  out  1  flush and redirect request.
- branch_cnt_o  out  32  resolved branches/jumps.
- mispred_cnt_o  out  32  mispredictions.

Behaviour:
- Index and tag fields:
  - idx = pc[INDEX_W+1:2].
  - tag = pc[INDEX_W+TAG_W+1:INDEX_W+2].
  - Each entry holds valid, tag, ctr[1:0], target[31:0].
- Fetch read is combinational:
  - hit_f = valid[idx_f] & (tag[idx_f] == tag_f).
  - pred_taken_f_o = hit_f & ctr[idx_f][1].
  - pred_target_f_o = target[idx_f] on a hit, else 0.
- Read/write to the same entry in one cycle: fetch sees the old contents; there is no bypass.
- Writes occur on the rising edge, only when instr_valid_e_i = 1.
- Real branch (update_en_e_i = 1), hit at pc_e_i:
  - Taken: ctr increments, saturating at 11.
  - Not taken: ctr decrements, saturating at 00.
  - If taken, target is overwritten with target_e_i.
- Real branch, miss:
  - Taken: allocate. valid = 1, tag written, target = target_e_i, ctr = 10. Any existing entry at that index is overwritten.
  - Not taken: no write.
- Non-branch (update_en_e_i = 0) with pred_taken_e_i = 1, i.e. an alias hit: clear valid at idx_e.
- mispredict_e_o is combinational and asserts when instr_valid_e_i is high and any of the following holds:
  - update_en_e_i & (pred_taken_e_i != pc_src_res_e_i);
  - update_en_e_i & pred_taken_e_i & pc_src_res_e_i & (pred_target_e_i != target_e_i);
  - ~update_en_e_i & pred_taken_e_i.
- mispredict_e_o is forced to 0 when instr_valid_e_i = 0.
- Performance counters:
  - branch_cnt_o increments on each valid update_en_e_i cycle.
  - mispred_cnt_o increments on each mispredict_e_o cycle.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- Reset (rst_n_i low at an edge, including mid-operation):
  - All valid = 0; all ctr = 01 (weakly not taken); targets and tags don't-care.
  - Both counters = 0.
  - During reset no table update occurs, regardless of E inputs.
- After reset: pred_taken_f_o = 0, pred_target_f_o = 0, mispredict_e_o follows its inputs.
- Table is flop-based so the single-cycle reset clear is possible.

Test Plan:
- Cold table, branch at PC 0x100 resolved taken to 0x80, pred_taken_e_i = 0:
  - mispredict_e_o = 1, mispred_cnt_o = 1.
  - Next cycle, pc_f_i = 0x100 gives pred_taken_f_o = 1, pred_target_f_o = 0x80, entry ctr = 10.
- Same branch resolved not taken twice:
  - ctr 10 -> 01 -> 00; pred_taken_f_o = 0.
  - Then three taken resolutions give ctr 11 and it stays 11 on a fourth taken.
- Aliasing:
  - PC 0x100 is allocated; pc_f_i = 0x180 (same idx, different tag) gives pred_taken_f_o = 0.
  - A non-branch at 0x100 arriving in E with pred_taken_e_i = 1 gives mispredict_e_o = 1 and invalidates the entry.
- Target mismatch: JALR hit predicted taken to 0x200, resolves taken to 0x300:
  - mispredict_e_o = 1.
  - Target is updated to 0x300; ctr increments.
- Flushed E slot: instr_valid_e_i = 0 with update_en_e_i = 1 and outcome mismatch:
  - mispredict_e_o = 0.
  - No table or counter change.
- Reset and saturation:
  - Assert rst_n_i = 0 for one edge after several allocations: all lookups miss, counters read 0.
  - Preload mispred_cnt_o to 32'hFFFF_FFFF (force), then cause a mispredict: value holds.
